// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the integer register file.
// Imported by the clear sequencer and the register file top.
package regfile_pkg;

    typedef enum logic {
        RF_CLEAR,
        RF_RUN
    } rf_state_e;

    localparam int RF_XLEN  = 32;
    localparam int RF_NREGS = 32;

endpackage

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: walks every register index once,
// zeroing it, then hands the array over to normal operation.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int NREGS = RF_NREGS,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    localparam logic [AW:0] LAST = (AW+1)'(NREGS - 1);

    rf_state_e   state;
    rf_state_e   state_n;
    logic [AW:0] cnt;
    logic [AW:0] cnt_n;

    // State and counter register; reset restarts the full sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RF_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Advance the sweep and leave CLEAR after the last index.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        clr_we  = 1'b0;
        unique case (state)
            RF_CLEAR: begin
                clr_we = !rst;
                cnt_n  = cnt + 1'b1;
                if (cnt == LAST) begin
                    state_n = RF_RUN;
                end
            end
            RF_RUN: begin
                cnt_n = cnt;
            end
            default: begin
                state_n = RF_CLEAR;
            end
        endcase
    end

    assign busy     = (state == RF_CLEAR);
    assign clr_addr = cnt[AW-1:0];

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with write bypass,
// debug tap and hardware clear after reset.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = RF_XLEN,
    parameter int NREGS    = RF_NREGS,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] rs,
    output logic [NRD*XLEN-1:0] rv,
    input  logic              we,
    input  logic [AW-1:0]     rd,
    input  logic [XLEN-1:0]   regdata,
    input  logic [AW-1:0]     dbg_addr,
    output logic [XLEN-1:0]   dbg_data,
    output logic              busy
);

    logic [XLEN-1:0] r [NREGS];
    logic            clr_we;
    logic [AW-1:0]   clr_addr;
    logic            rd_zero;
    logic            wr_en;

    regfile_clear_seq #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_clr (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Writes during clear or reset are dropped, not deferred.
    assign rd_zero = (ZERO_REG != 0) && (rd == '0);
    assign wr_en   = we && !busy && !rst && !rd_zero;

    // Array update; the clear sweep wins over the write port.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            r[clr_addr] <= '0;
        end else if (wr_en) begin
            r[rd] <= regdata;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] ra;
        assign ra = rs[k*AW +: AW];
        assign rv[k*XLEN +: XLEN] =
            busy ? '0 :
            ((ZERO_REG != 0) && (ra == '0)) ? '0 :
            ((BYPASS != 0) && wr_en && (rd == ra)) ? regdata :
            r[ra];
    end

    assign dbg_data =
        busy ? '0 :
        ((ZERO_REG != 0) && (dbg_addr == '0)) ? '0 :
        r[dbg_addr];

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port integer register file; next generation of the core's 32x32 two-read regfile.
- Sits between decode (read addresses) and writeback (write port) of the RISC-V core.
- Adds over the previous generation:
  - configurable width, depth and read-port count
  - same-cycle write-to-read bypass
  - a generic debug read port
  - a hardware clear sequencer run after reset, which replaces simulation-only initial blocks.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of registers; power of two, minimum 2.
- NRD, 2, number of combinational read ports, 1..4.
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes.
- BYPASS, 1, 1 = a write in the same cycle is forwarded to matching read ports.
- AW, $clog2(NREGS), address width (derived, not overridden).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- rs  in  NRD*AW  read addresses; port k at bits [k*AW +: AW].
- rv  out  NRD*XLEN  read data; port k at bits [k*XLEN +: XLEN].
- we  in  1  write enable.
- rd  in  AW  write address.
- regdata  in  XLEN  write data.
- dbg_addr  in  AW  debug read address.
- dbg_data  out  XLEN  debug read data; no bypass applied.
- busy  out  1  high while the clear sequence runs.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- FSM states: CLEAR, RUN.
- rst high at a rising edge: state <= CLEAR, clear counter <= 0.
  - rst held high keeps the state at CLEAR with counter 0; nothing is written.
- CLEAR (rst low):
  - Each cycle, r[cnt] <= 0 and cnt <= cnt+1.
  - After writing index NREGS-1, state <= RUN.
  - Duration is exactly NREGS cycles after rst deasserts.
- busy = (state == CLEAR). It is 1 from the first edge with rst high until the edge that completes index NREGS-1.
- While busy:
  - we is ignored; the write is dropped, not queued.
  - All rv ports and dbg_data drive 0.
- RUN:
  - Write at the rising edge when we=1, unless ZERO_REG=1 and rd=0.
  - Read ports are combinational: rv[k] = r[rs[k]].
- Zero register: when ZERO_REG=1, rs[k]=0 or dbg_addr=0 returns 0 regardless of array contents.
- Bypass (BYPASS=1, state RUN):
  - If we=1, rd==rs[k] and the write is not suppressed by ZERO_REG, then rv[k] = regdata in the same cycle.
  - Applies independently to each port; multiple ports may bypass at once.
- No bypass (BYPASS=0): rv[k] shows the old value until the edge after the write.
- dbg_data = r[dbg_addr], never bypassed. This generalises the old fixed x31 tap; software sets dbg_addr=31 for that use.
- Reset mid-clear: counter restarts at 0 and the full sequence repeats.
- Reset during RUN: re-enters CLEAR; all registers end at 0.
- Latency:
  - read: 0 cycles
  - write to visible: same cycle with BYPASS, else 1 cycle
  - reset release to usable: NREGS cycles
- Widths: addresses are exactly AW bits, so no out-of-range index is possible. The counter is AW+1 bits so the terminal compare is unambiguous.

Decomposition:
- Shared package regfile_pkg holds:
  - the state enum rf_state_e {RF_CLEAR, RF_RUN}
  - the default XLEN and NREGS constants used by the core.
- Sub-module regfile_clear_seq: FSM plus counter; outputs busy, clr_we, clr_addr.
- regfile_mp contains the array, write arbitration (clear has priority over we), the read muxes and the bypass.

Test Plan:
- Defaults; rst high 2 cycles then low -> busy=1 for exactly 32 cycles after release; rv all 0; afterwards r[5] reads 0 (not 5).
- After clear: we=1, rd=7, regdata=0xDEADBEEF, rs0=7 in the same cycle -> rv0=0xDEADBEEF the same cycle. With BYPASS=0 -> rv0=0 that cycle, 0xDEADBEEF the next.
- we=1, rd=0, regdata=0x1234 -> rv for rs=0 stays 0, including the write cycle. With ZERO_REG=0 -> reads 0x1234 the next cycle.
- During busy: we=1, rd=3, regdata=0xAA -> after clear completes, r[3]=0 and dbg_addr=3 gives dbg_data=0.
- Write r[31]=0x55 and r[9]=0x66; then rst for 1 cycle at clear index 10, then release -> busy lasts 32 more cycles; afterwards r[31]=0 and r[9]=0.
- NRD=4, XLEN=64, NREGS=16; write r[2]=0x0123456789ABCDEF; set rs={2,2,0,15} with we=1, rd=15, regdata=1 -> rv={0x0123456789ABCDEF, 0x0123456789ABCDEF, 0, 1}.
